// File: rtl/ram_access_arbiter_pkg.sv
// Shared configuration for the RAM access arbiter slice.
//   CFG_DATA_WIDTH / CFG_ADDR_WIDTH : RAM geometry used across the design
//   NUM_REQ_DEF / ARB_TIMEOUT_DEF   : default requester count and read timeout
//   arb_state_e                     : arbiter FSM state encoding
package ram_access_arbiter_pkg;

  localparam int unsigned CFG_DATA_WIDTH  = 8;
  localparam int unsigned CFG_ADDR_WIDTH  = 4;
  localparam int unsigned NUM_REQ_DEF     = 2;
  localparam int unsigned ARB_TIMEOUT_DEF = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WRITE,
    ARB_RD_ISSUE,
    ARB_RD_WAIT
  } arb_state_e;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the arbiter.
//   req_*         : requester handshake (valid/we/addr/wdata in, ready out)
//   rsp_*         : completion pulse, read data and timeout flag back to requesters
//   ram_*         : pins toward the single-port RAM and its read return
//   busy          : arbiter has a transaction in flight
// Modports: slave = arbiter, master = requesters plus RAM environment.
interface ram_access_arbiter_if
  import ram_access_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned DATA_WIDTH = CFG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = CFG_ADDR_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;
  logic                          ram_en;
  logic [ADDR_WIDTH-1:0]         ram_address;
  logic [DATA_WIDTH-1:0]         ram_data_in;
  logic [DATA_WIDTH-1:0]         ram_data_out;
  logic                          ram_valid_out;
  logic                          busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_data_out, ram_valid_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_en, ram_address, ram_data_in, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_data_out, ram_valid_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_en, ram_address, ram_data_in, busy
  );

endinterface

// File: rtl/ram_access_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : request vector
//   ptr_i : index of the last winner; search starts at ptr_i+1 and wraps
//   gnt_o : one-hot grant (all zero when no request)
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    // Offset N wraps back to ptr_i itself, so the last winner is checked last.
    for (int unsigned i = 1; i <= N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && (j == (32'(ptr_i) + i) % N) && req_i[j]) begin
          gnt_o[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one single-port RAM among NUM_REQ requesters, round-robin, one
// transaction in flight at a time.
//   clk    : rising-edge clock
//   rstn   : asynchronous active-low reset
//   bus_io : requester handshake, responses and RAM pins (slave modport)
// Write: accept -> WRITE (ram_en=1, completion pulse) -> IDLE.
// Read : accept -> READ_ISSUE -> READ_WAIT until valid_out or timeout -> IDLE.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned DATA_WIDTH = CFG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = CFG_ADDR_WIDTH,
  parameter int unsigned TIMEOUT    = ARB_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  ram_access_arbiter_if.slave bus_io
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT);

  arb_state_e state_q, state_d;

  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ram_en_q, ram_en_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [DATA_WIDTH-1:0] ram_data_in_q, ram_data_in_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  accept;
  logic [IdxW-1:0]       win_idx;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [NUM_REQ-1:0]    owner_hot;
  logic                  timed_out;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req_i (bus_io.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  // Grants are only offered in IDLE; a grant implies req_valid, so any ready bit is an accept.
  assign req_ready = (state_q == ARB_IDLE) ? gnt : '0;
  assign accept    = |req_ready;
  assign timed_out = (cnt_q == CntW'(TIMEOUT - 1));

  // Winner's fields, muxed by the one-hot grant.
  always_comb begin
    win_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_idx   = IdxW'(i);
        sel_we    = bus_io.req_we[i];
        sel_addr  = bus_io.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus_io.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    owner_hot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      owner_hot[i] = (owner_q == IdxW'(i));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          state_d = sel_we ? ARB_WRITE : ARB_RD_ISSUE;
        end
      end
      ARB_WRITE:    state_d = ARB_IDLE;
      ARB_RD_ISSUE: state_d = ARB_RD_WAIT;
      ARB_RD_WAIT: begin
        if (bus_io.ram_valid_out || timed_out) begin
          state_d = ARB_IDLE;
        end
      end
      default:      state_d = ARB_IDLE;
    endcase
  end

  // Output / datapath next-state logic.
  always_comb begin
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    ram_en_d      = ram_en_q;
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;
    rsp_valid_d   = '0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          ptr_d         = win_idx;
          owner_d       = win_idx;
          ram_en_d      = sel_we;
          ram_address_d = sel_addr;
          ram_data_in_d = sel_wdata;
          // Write completion lines up with the single WRITE cycle.
          if (sel_we) begin
            rsp_valid_d = gnt;
            rsp_err_d   = 1'b0;
          end
        end
      end
      ARB_WRITE: begin
        ram_en_d = 1'b0;
      end
      ARB_RD_ISSUE: begin
        // Any valid_out seen here belongs to an earlier read and is ignored.
        cnt_d = '0;
      end
      ARB_RD_WAIT: begin
        if (bus_io.ram_valid_out) begin
          rsp_rdata_d = bus_io.ram_data_out;
          rsp_valid_d = owner_hot;
          rsp_err_d   = 1'b0;
        end else if (timed_out) begin
          rsp_valid_d = owner_hot;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q         <= IdxW'(NUM_REQ - 1);
      owner_q       <= '0;
      cnt_q         <= '0;
      ram_en_q      <= 1'b0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      ram_en_q      <= ram_en_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign bus_io.req_ready   = req_ready;
  assign bus_io.rsp_valid   = rsp_valid_q;
  assign bus_io.rsp_rdata   = rsp_rdata_q;
  assign bus_io.rsp_err     = rsp_err_q;
  assign bus_io.ram_en      = ram_en_q;
  assign bus_io.ram_address = ram_address_q;
  assign bus_io.ram_data_in = ram_data_in_q;
  assign bus_io.busy        = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural single-port RAM.
module tb_ram_access_arbiter;

  localparam int NR = 2;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic ram_dead = 1'b0;
  logic [DW-1:0] mem [2**AW];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_access_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_access_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TO)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus_io (bus)
  );

  // RAM model: registered read data and valid one cycle after an en=0 cycle.
  always @(posedge clk) begin
    if (bus.ram_en) mem[bus.ram_address] <= bus.ram_data_in;
    else            bus.ram_data_out <= mem[bus.ram_address];
    bus.ram_valid_out <= !bus.ram_en && !ram_dead;
  end

  typedef struct {
    int          r;
    bit          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int r, input bit v, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.req_valid[r]           = v;
    bus.req_we[r]              = we;
    bus.req_addr[r*AW +: AW]   = a;
    bus.req_wdata[r*DW +: DW]  = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_en"},    32'(bus.ram_en), 0);
    check({tag, "_ram_addr"},  32'(bus.ram_address), 0);
    check({tag, "_ram_din"},   32'(bus.ram_data_in), 0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    check({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 0);
    check({tag, "_rsp_err"},   32'(bus.rsp_err), 0);
    check({tag, "_busy"},      32'(bus.busy), 0);
  endtask

  // One transaction: wait for grant, then count cycles from accept to rsp_valid.
  task automatic do_txn(input string tag, input int r, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rdata,
                        output logic err);
    int waitc = 0;
    lat = 0;
    @(negedge clk);
    set_req(r, 1'b1, we, a, d);
    #1;
    while (!bus.req_ready[r] && waitc < 20) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!bus.req_ready[r]) begin
      check({tag, "_grant_wait"}, 32'(bus.req_ready[r]), 1);
      set_req(r, 1'b0, we, a, d);
      rdata = 'x;
      err   = 1'bx;
      return;
    end
    @(negedge clk);
    set_req(r, 1'b0, we, a, d);
    lat = 1;
    check({tag, "_ram_en_c1"},   32'(bus.ram_en), 32'(we));
    check({tag, "_ram_addr_c1"}, 32'(bus.ram_address), 32'(a));
    if (we) check({tag, "_ram_din_c1"}, 32'(bus.ram_data_in), 32'(d));
    while (bus.rsp_valid == '0 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_rsp_owner"}, 32'(bus.rsp_valid), 32'(1) << r);
    check({tag, "_busy_at_rsp"}, 32'(bus.busy), 32'(we));
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [DW-1:0] rd;
    logic er;
    logic [DW-1:0] hold_rdata;
    string tag;

    vecs[0] = '{0, 1'b1, 4'd5,  8'hA5, 8'h00, 1};
    vecs[1] = '{0, 1'b0, 4'd5,  8'h00, 8'hA5, 3};
    vecs[2] = '{1, 1'b1, 4'd3,  8'h3C, 8'h00, 1};
    vecs[3] = '{1, 1'b0, 4'd3,  8'h00, 8'h3C, 3};
    vecs[4] = '{1, 1'b0, 4'd5,  8'h00, 8'hA5, 3};
    vecs[5] = '{1, 1'b1, 4'd15, 8'hFF, 8'h00, 1};
    vecs[6] = '{0, 1'b0, 4'd15, 8'h00, 8'hFF, 3};
    vecs[7] = '{0, 1'b1, 4'd1,  8'h11, 8'h00, 1};
    vecs[8] = '{1, 1'b1, 4'd2,  8'h22, 8'h00, 1};
    vecs[9] = '{0, 1'b0, 4'd2,  8'h00, 8'h22, 3};

    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    hold_rdata    = '0;

    // Reset state.
    #12;
    check_all_zero("reset");
    check("reset_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Table-driven transactions.
    for (int i = 0; i < 10; i++) begin
      tag = $sformatf("vec%0d", i);
      do_txn(tag, vecs[i].r, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, er);
      check({tag, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
      check({tag, "_err"}, 32'(er), 0);
      if (!vecs[i].we) begin
        hold_rdata = vecs[i].exp_rdata;
        check({tag, "_rdata"}, 32'(rd), 32'(vecs[i].exp_rdata));
      end
    end

    // Boundary write; address/data must hold while idle.
    do_txn("bnd_wr", 1, 1'b1, 4'd15, 8'hFF, lat, rd, er);
    check("bnd_wr_latency", 32'(lat), 1);
    check("bnd_wr_rdata_unchanged", 32'(rd), 32'(hold_rdata));
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("bnd_idle_addr_hold", 32'(bus.ram_address), 15);
    check("bnd_idle_din_hold",  32'(bus.ram_data_in), 32'hFF);
    check("bnd_idle_en",        32'(bus.ram_en), 0);
    check("bnd_idle_busy",      32'(bus.busy), 0);

    // Read timeout: RAM never answers.
    ram_dead = 1'b1;
    do_txn("timeout", 0, 1'b0, 4'd5, 8'h00, lat, rd, er);
    check("timeout_latency", 32'(lat), TO + 2);
    check("timeout_err", 32'(er), 1);
    check("timeout_rdata_held", 32'(rd), 32'(hold_rdata));
    ram_dead = 1'b0;

    // Withdrawn request while busy.
    begin
      int n0 = 0, n1 = 0, nr1 = 0;
      @(negedge clk);
      set_req(0, 1'b1, 1'b0, 4'd5, 8'h00);
      #1;
      check("wd_grant0", 32'(bus.req_ready), 32'b01);
      @(negedge clk);
      set_req(0, 1'b0, 1'b0, 4'd5, 8'h00);
      set_req(1, 1'b1, 1'b0, 4'd3, 8'h00);
      #1;
      check("wd_ready_while_busy", 32'(bus.req_ready), 0);
      @(negedge clk);
      set_req(1, 1'b0, 1'b0, 4'd3, 8'h00);
      for (int i = 0; i < 8; i++) begin
        #1;
        if (bus.rsp_valid[0]) n0++;
        if (bus.rsp_valid[1]) n1++;
        if (bus.req_ready[1]) nr1++;
        if (bus.rsp_valid[0]) check("wd_rdata", 32'(bus.rsp_rdata), 32'hA5);
        @(negedge clk);
      end
      check("wd_rsp0_count", 32'(n0), 1);
      check("wd_rsp1_count", 32'(n1), 0);
      check("wd_ready1_count", 32'(nr1), 0);
    end

    // Reset in the middle of READ_WAIT.
    begin
      int nrsp = 0;
      ram_dead = 1'b1;
      @(negedge clk);
      set_req(1, 1'b1, 1'b0, 4'd3, 8'h00);
      #1;
      check("rst_mid_grant1", 32'(bus.req_ready), 32'b10);
      @(negedge clk);
      set_req(1, 1'b0, 1'b0, 4'd3, 8'h00);
      @(negedge clk);
      @(negedge clk);
      check("rst_mid_busy_before", 32'(bus.busy), 1);
      #2;
      rstn = 1'b0;
      #1;
      check_all_zero("rst_mid");
      @(negedge clk);
      ram_dead = 1'b0;
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
        #1;
        if (bus.rsp_valid != '0) nrsp++;
        @(negedge clk);
      end
      check("rst_mid_no_rsp", 32'(nrsp), 0);
    end

    // Contention after reset: grants alternate starting with requester 0.
    begin
      int grants = 0, rsps = 0, pending = 0, exp_g = 0;
      set_req(0, 1'b1, 1'b0, 4'd1, 8'h00);
      set_req(1, 1'b1, 1'b0, 4'd2, 8'h00);
      for (int cyc = 0; cyc < 40 && rsps < 4; cyc++) begin
        if (grants == 4) begin
          set_req(0, 1'b0, 1'b0, 4'd1, 8'h00);
          set_req(1, 1'b0, 1'b0, 4'd2, 8'h00);
        end
        #1;
        if (bus.rsp_valid != '0) begin
          check($sformatf("cont_rsp%0d_owner", rsps), 32'(bus.rsp_valid), 32'(1) << pending);
          check($sformatf("cont_rsp%0d_rdata", rsps), 32'(bus.rsp_rdata),
                (pending == 0) ? 32'h11 : 32'h22);
          check($sformatf("cont_rsp%0d_err", rsps), 32'(bus.rsp_err), 0);
          rsps++;
        end
        if (bus.req_ready != '0 && grants < 4) begin
          check($sformatf("cont_grant%0d", grants), 32'(bus.req_ready), 32'(1) << exp_g);
          pending = exp_g;
          exp_g   = 1 - exp_g;
          grants++;
        end
        @(negedge clk);
      end
      set_req(0, 1'b0, 1'b0, 4'd1, 8'h00);
      set_req(1, 1'b0, 1'b0, 4'd2, 8'h00);
      check("cont_grant_count", 32'(grants), 4);
      check("cont_rsp_count", 32'(rsps), 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
